sram_arbiter: RTL

//  Shares the single async 16-bit SRAM between the VGA scan-out reader (display port) and the

---
 rtl/sram_arb_pkg.sv | 36 +++
 rtl/sram_phy.sv | 134 +++++++++++++
 rtl/sram_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and default sizes for the SRAM arbiter and its pin-level PHY.
//   phase_e : what the SRAM pins do in a given cycle (idle, read, write,
//             bus turnaround after a write)
//   owner_e : which client an access belongs to (display scan-out or engine)
// -----------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int ARB_ADDR_W       = 20;
    localparam int ARB_DATA_W       = 16;
    localparam int ARB_ENG_MAX_WAIT = 64;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_RD   = 2'd1,
        PH_WR   = 2'd2,
        PH_TURN = 2'd3
    } phase_e;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_ENG  = 1'b1
    } owner_e;

    // True for phases that actually touch the memory array.
    function automatic logic phase_is_access(input phase_e ph);
        logic acc_s;
        case (ph)
            PH_RD, PH_WR: acc_s = 1'b1;
            default:      acc_s = 1'b0;
        endcase
        return acc_s;
    endfunction

endpackage

// File: rtl/sram_phy.sv
// -----------------------------------------------------------------------------
// sram_phy
// Pin-level side of the SRAM arbiter. Registers the phase chosen by the
// arbiter so that every SRAM pin comes straight from a flop, owns the DQ
// tristate, and captures read data into the per-client read data registers.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   phase_i           phase for the next cycle (arbiter's next-state)
//   addr_i, wdata_i   address / write data for that access
//   cap_disp_i        pins are in a display read this cycle: capture DQ
//   cap_eng_i         pins are in an engine read this cycle: capture DQ
//   disp_rdata_o      display read data (holds between reads)
//   eng_rdata_o       engine read data (holds between reads)
//   sram_*            SRAM pins (strobes active low)
// -----------------------------------------------------------------------------
module sram_phy
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  phase_e            phase_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              cap_disp_i,
    input  logic              cap_eng_i,
    output logic [DATA_W-1:0] disp_rdata_o,
    output logic [DATA_W-1:0] eng_rdata_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    inout  wire  [DATA_W-1:0] sram_dq_io,
    output logic              sram_we_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_ce_n_o,
    output logic              sram_ub_n_o,
    output logic              sram_lb_n_o
);

    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_n_q,  we_n_d;
    logic              oe_n_q,  oe_n_d;
    logic              ce_n_q,  ce_n_d;
    logic              bytes_n_q, bytes_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
    logic [DATA_W-1:0] eng_rdata_q,  eng_rdata_d;
    logic [DATA_W-1:0] dq_in_s;

    // Data bus is only ever driven by us during a write phase.
    assign sram_dq_io = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
    assign dq_in_s    = sram_dq_io;

    // Next pin state from the phase the arbiter picked; address holds when idle.
    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        ce_n_d    = 1'b1;
        bytes_n_d = 1'b1;
        dq_oe_d   = 1'b0;
        case (phase_i)
            PH_RD: begin
                addr_d    = addr_i;
                ce_n_d    = 1'b0;
                oe_n_d    = 1'b0;
                bytes_n_d = 1'b0;
            end
            PH_WR: begin
                addr_d    = addr_i;
                wdata_d   = wdata_i;
                ce_n_d    = 1'b0;
                we_n_d    = 1'b0;
                bytes_n_d = 1'b0;
                dq_oe_d   = 1'b1;
            end
            default: begin
                // IDLE and TURN: chip deselected, bus released.
                ce_n_d = 1'b1;
            end
        endcase
    end

    // Read data capture: each client keeps its own last value.
    always_comb begin
        if (cap_disp_i) begin
            disp_rdata_d = dq_in_s;
        end else begin
            disp_rdata_d = disp_rdata_q;
        end
        if (cap_eng_i) begin
            eng_rdata_d = dq_in_s;
        end else begin
            eng_rdata_d = eng_rdata_q;
        end
    end

    // Pin and read data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            ce_n_q       <= 1'b1;
            bytes_n_q    <= 1'b1;
            dq_oe_q      <= 1'b0;
            disp_rdata_q <= {DATA_W{1'b0}};
            eng_rdata_q  <= {DATA_W{1'b0}};
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_n_q       <= we_n_d;
            oe_n_q       <= oe_n_d;
            ce_n_q       <= ce_n_d;
            bytes_n_q    <= bytes_n_d;
            dq_oe_q      <= dq_oe_d;
            disp_rdata_q <= disp_rdata_d;
            eng_rdata_q  <= eng_rdata_d;
        end
    end

    assign sram_addr_o  = addr_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_ub_n_o  = bytes_n_q;
    assign sram_lb_n_o  = bytes_n_q;
    assign disp_rdata_o = disp_rdata_q;
    assign eng_rdata_o  = eng_rdata_q;

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one async 16-bit SRAM between the VGA display reader and the
// drawing engine. Display reads win by default; the engine takes free slots
// and, after ENG_MAX_WAIT stalled cycles, pre-empts one display slot. A write
// followed by anything other than another write costs one TURN cycle.
// Timeline: decision in cycle 0, pins active in cycle 1, read data and
// Rvalid/Miss visible in cycle 2.
// Ports:
//   iCLK, iRST_N                    clock, async active-low reset
//   iDisp_Req/Addr                  display read request, sampled every cycle
//   oDisp_Rvalid/Rdata/Miss         display result, 2 cycles after request
//   iEng_Req/We/Addr/Wdata          engine request, held until oEng_Gnt
//   oEng_Gnt                        combinational accept strobe
//   oEng_Rvalid/Rdata               engine read result, 2 cycles after grant
//   oSRAM_*, ioSRAM_DQ              SRAM pins
// -----------------------------------------------------------------------------
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int ENG_MAX_WAIT = ARB_ENG_MAX_WAIT
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iDisp_Req,
    input  logic [ADDR_W-1:0] iDisp_Addr,
    output logic              oDisp_Rvalid,
    output logic              oDisp_Miss,
    output logic [DATA_W-1:0] oDisp_Rdata,
    input  logic              iEng_Req,
    input  logic              iEng_We,
    input  logic [ADDR_W-1:0] iEng_Addr,
    input  logic [DATA_W-1:0] iEng_Wdata,
    output logic              oEng_Gnt,
    output logic              oEng_Rvalid,
    output logic [DATA_W-1:0] oEng_Rdata,
    output logic [ADDR_W-1:0] oSRAM_ADDR,
    inout  wire  [DATA_W-1:0] ioSRAM_DQ,
    output logic              oSRAM_WE_N,
    output logic              oSRAM_OE_N,
    output logic              oSRAM_CE_N,
    output logic              oSRAM_UB_N,
    output logic              oSRAM_LB_N
);

    localparam int              CNT_W    = $clog2(ENG_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(ENG_MAX_WAIT);

    // state_q is the phase currently on the pins; owner_q says whose it is.
    phase_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              miss_p1_q, miss_p1_d;
    logic              disp_miss_q, disp_miss_d;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic              eng_rvalid_q, eng_rvalid_d;
    logic              gnt_s;
    logic              starve_s;
    logic              eng_wr_ok_s;
    logic              cap_disp_s;
    logic              cap_eng_s;
    logic [ADDR_W-1:0] addr_s;

    assign starve_s = (wait_cnt_q == WAIT_MAX);
    // While a write is on the pins, only another engine write may follow
    // without a turnaround, and only if the engine would win this slot anyway.
    assign eng_wr_ok_s = iEng_Req && iEng_We && (starve_s || !iDisp_Req);

    // Arbitration and next phase.
    always_comb begin
        state_d   = PH_IDLE;
        owner_d   = OWN_DISP;
        gnt_s     = 1'b0;
        miss_p1_d = 1'b0;
        addr_s    = iDisp_Addr;
        if ((state_q == PH_WR) && !eng_wr_ok_s) begin
            state_d   = PH_TURN;
            miss_p1_d = iDisp_Req;
        end else if (starve_s && iEng_Req) begin
            state_d   = iEng_We ? PH_WR : PH_RD;
            owner_d   = OWN_ENG;
            gnt_s     = 1'b1;
            addr_s    = iEng_Addr;
            miss_p1_d = iDisp_Req;
        end else if (iDisp_Req) begin
            state_d = PH_RD;
            owner_d = OWN_DISP;
            addr_s  = iDisp_Addr;
        end else if (iEng_Req) begin
            state_d = iEng_We ? PH_WR : PH_RD;
            owner_d = OWN_ENG;
            gnt_s   = 1'b1;
            addr_s  = iEng_Addr;
        end else begin
            state_d = PH_IDLE;
        end
    end

    // Engine stall counter: saturates, cleared by grant or by dropping the request.
    always_comb begin
        if (!iEng_Req || gnt_s) begin
            wait_cnt_d = {CNT_W{1'b0}};
        end else if (starve_s) begin
            wait_cnt_d = wait_cnt_q;
        end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Result strobes for the access currently on the pins.
    always_comb begin
        cap_disp_s    = (state_q == PH_RD) && (owner_q == OWN_DISP);
        cap_eng_s     = (state_q == PH_RD) && (owner_q == OWN_ENG);
        disp_rvalid_d = cap_disp_s;
        eng_rvalid_d  = cap_eng_s;
        disp_miss_d   = miss_p1_q;
    end

    // Phase, owner, stall counter and result pipeline registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q       <= PH_IDLE;
            owner_q       <= OWN_DISP;
            wait_cnt_q    <= {CNT_W{1'b0}};
            miss_p1_q     <= 1'b0;
            disp_miss_q   <= 1'b0;
            disp_rvalid_q <= 1'b0;
            eng_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            wait_cnt_q    <= wait_cnt_d;
            miss_p1_q     <= miss_p1_d;
            disp_miss_q   <= disp_miss_d;
            disp_rvalid_q <= disp_rvalid_d;
            eng_rvalid_q  <= eng_rvalid_d;
        end
    end

    // The grant is combinational, so it must also be silenced while in reset.
    assign oEng_Gnt     = gnt_s & iRST_N;
    assign oDisp_Rvalid = disp_rvalid_q;
    assign oDisp_Miss   = disp_miss_q;
    assign oEng_Rvalid  = eng_rvalid_q;

    sram_phy #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_phy (
        .clk          (iCLK),
        .rst_n        (iRST_N),
        .phase_i      (state_d),
        .addr_i       (addr_s),
        .wdata_i      (iEng_Wdata),
        .cap_disp_i   (cap_disp_s),
        .cap_eng_i    (cap_eng_s),
        .disp_rdata_o (oDisp_Rdata),
        .eng_rdata_o  (oEng_Rdata),
        .sram_addr_o  (oSRAM_ADDR),
        .sram_dq_io   (ioSRAM_DQ),
        .sram_we_n_o  (oSRAM_WE_N),
        .sram_oe_n_o  (oSRAM_OE_N),
        .sram_ce_n_o  (oSRAM_CE_N),
        .sram_ub_n_o  (oSRAM_UB_N),
        .sram_lb_n_o  (oSRAM_LB_N)
    );

endmodule
